// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative DIV/DIVU unit.
//   - FSM state encoding (IDLE/CALC/FIN) as plain logic constants.
//   - MIPS funct codes for DIV/DIVU and a helper the execute stage uses to
//     derive signed_i from the decoded instruction.
//   - Response record (Lo, Hi, divide-by-zero flag) for consumers and models.
package div_unit_pkg;

  localparam int DIV_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  // DIV is the signed form; DIVU (and anything else) is treated as unsigned.
  function automatic logic funct_is_signed(input logic [5:0] funct);
    return funct == FUNCT_DIV;
  endfunction

  typedef struct packed {
    logic [DIV_W-1:0] lo;
    logic [DIV_W-1:0] hi;
    logic             dz;
  } div_rsp_t;

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage <-> divider handshake and HiLo write bundle.
//   master (execute): drives start_i, signed_i, dividend_i, divisor_i, cancel_i
//   slave  (divider): drives busy, done, wLoData/wlo, wHiData/whi, divZero
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             cancel_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] wLoData;
  logic             wlo;
  logic [WIDTH-1:0] wHiData;
  logic             whi;
  logic             divZero;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  busy, done, wLoData, wlo, wHiData, whi, divZero
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output busy, done, wLoData, wlo, wHiData, whi, divZero
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division step.
//   r      : partial remainder (always < d on entry)
//   q      : shift register holding the remaining dividend bits (MSB first)
//            and, from the bottom, the quotient bits produced so far
//   d      : divisor magnitude (non-zero)
//   r_next : updated partial remainder
//   q_next : q shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  // The shifted remainder is kept one bit wider: with a divisor above
  // 2^(WIDTH-1) the remainder can reach bit WIDTH-1, and shifting it left
  // must not drop that bit before the compare.
  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    r_sh   = {r, q[WIDTH-1]};
    ge     = r_sh >= {1'b0, d};
    diff   = r_sh - {1'b0, d};
    q_next = {q[WIDTH-2:0], 1'b0};
    r_next = r_sh[WIDTH-1:0];
    if (ge) begin
      // r_sh < 2*d, so the difference always fits back into WIDTH bits.
      r_next    = diff[WIDTH-1:0];
      q_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : div_unit_if.slave
//     start_i/signed_i/dividend_i/divisor_i : operation request, sampled in IDLE
//     cancel_i : flush; aborts CALC, masks the FIN write strobes
//     busy     : stall to execute (also combinationally on an accepted start)
//     done/wlo/whi : one-cycle completion and HiLo write enables
//     wLoData/wHiData : quotient/remainder, held until the next completion
//     divZero  : divisor was zero, qualified by done
// One quotient bit is produced per cycle on operand magnitudes; signs are
// applied when the last step is registered into the result flops.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6   // must satisfy 2**CNT_W > WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] dv_q,    dv_d;
  logic             negq_q,  negq_d;
  logic             negr_q,  negr_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic             dz_q,    dz_d;

  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;
  logic             accept;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (dv_q),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Cancel outranks a simultaneous start.
  assign accept = (state_q == ST_IDLE) && bus.start_i && !bus.cancel_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dv_d    = dv_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          negq_d = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
          negr_d = bus.signed_i & bus.dividend_i[WIDTH-1];
          if (bus.divisor_i == '0) begin
            // Divide by zero skips the iteration entirely.
            lo_d    = '1;
            hi_d    = bus.dividend_i;
            dz_d    = 1'b1;
            state_d = ST_FIN;
          end else begin
            r_d     = '0;
            q_d     = mag(bus.dividend_i, bus.signed_i);
            dv_d    = mag(bus.divisor_i,  bus.signed_i);
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        if (bus.cancel_i) begin
          // Abort without touching the visible results.
          state_d = ST_IDLE;
        end else begin
          r_d   = step_r;
          q_d   = step_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Last step: register the sign-corrected results directly.
            lo_d    = negq_q ? (~step_q + 1'b1) : step_q;
            hi_d    = negr_q ? (~step_r + 1'b1) : step_r;
            state_d = ST_FIN;
          end
        end
      end

      ST_FIN:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dv_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dv_q    <= dv_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
    end
  end

  // busy covers the start cycle itself so execute stalls without a bubble.
  assign bus.busy    = (state_q == ST_CALC) || accept;
  assign bus.done    = (state_q == ST_FIN) && !bus.cancel_i;
  assign bus.wlo     = bus.done;
  assign bus.whi     = bus.done;
  assign bus.divZero = bus.done && dz_q;
  assign bus.wLoData = lo_q;
  assign bus.wHiData = hi_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_unit_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    div_rsp_t    exp;
  } vec_t;

  vec_t        vt[12];
  div_rsp_t    sb[$];
  logic [31:0] last_lo;
  logic [31:0] last_hi;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic div_rsp_t rsp(input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    div_rsp_t r;
    r.lo = lo; r.hi = hi; r.dz = dz;
    return r;
  endfunction

  function automatic vec_t mk(input logic s, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] lo, input logic [31:0] hi, input logic dz);
    vec_t v;
    v.s = s; v.a = a; v.b = b; v.exp = rsp(lo, hi, dz);
    return v;
  endfunction

  // Reference using the language's own division operators.
  function automatic div_rsp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    div_rsp_t r;
    if (b == 32'd0) begin
      r = rsp(32'hFFFF_FFFF, a, 1'b1);
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = rsp(32'h8000_0000, 32'd0, 1'b0);
    end else if (s) begin
      r.lo = $signed(a) / $signed(b);
      r.hi = $signed(a) % $signed(b);
      r.dz = 1'b0;
    end else begin
      r = rsp(a / b, a % b, 1'b0);
    end
    return r;
  endfunction

  task automatic count_no_done(input int n, input string nm);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (dif.done || dif.wlo || dif.whi) nd++;
    end
    chk(nm, nd, 0);
  endtask

  // Issue one operation, push its expectation, wait (bounded) for done and
  // compare against the popped scoreboard entry. mid_at > 0 pulses an extra
  // start with different operands at that cycle of CALC.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input div_rsp_t exp, input int mid_at, input string nm);
    int       lat;
    int       exp_lat;
    div_rsp_t e;
    exp_lat = exp.dz ? 1 : 33;
    @(negedge clk);
    dif.start_i    = 1'b1;
    dif.signed_i   = s;
    dif.dividend_i = a;
    dif.divisor_i  = b;
    sb.push_back(exp);
    #1 chk({nm, "_busy_start"}, dif.busy, 1);
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    lat = 1;
    chk({nm, "_busy1"}, dif.busy, !exp.dz);
    while (!dif.done && lat < 100) begin
      if (lat == mid_at) begin
        dif.start_i    = 1'b1;
        dif.dividend_i = 32'd1000;
        dif.divisor_i  = 32'd3;
      end else begin
        dif.start_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    dif.start_i = 1'b0;
    if (!dif.done) begin
      chk({nm, "_timeout"}, dif.done, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({nm, "_lat"}, lat, exp_lat);
      chk({nm, "_lo"},  dif.wLoData, e.lo);
      chk({nm, "_hi"},  dif.wHiData, e.hi);
      chk({nm, "_dz"},  dif.divZero, e.dz);
      chk({nm, "_wlo"}, dif.wlo, 1);
      chk({nm, "_whi"}, dif.whi, 1);
      chk({nm, "_busyfin"}, dif.busy, 0);
      last_lo = e.lo;
      last_hi = e.hi;
      @(posedge clk); #1;
      chk({nm, "_done_pulse"}, dif.done, 0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, dif.busy, 0);
    chk({nm, "_done"}, dif.done, 0);
    chk({nm, "_wlo"},  dif.wlo, 0);
    chk({nm, "_whi"},  dif.whi, 0);
    chk({nm, "_dz"},   dif.divZero, 0);
    chk({nm, "_lo"},   dif.wLoData, 0);
    chk({nm, "_hi"},   dif.wHiData, 0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a;
    logic [31:0] b;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.start_i = 1'b0;
    dif.signed_i = 1'b0;
    dif.dividend_i = '0;
    dif.divisor_i = '0;
    dif.cancel_i = 1'b0;
    last_lo = '0;
    last_hi = '0;

    vt[0]  = mk(0, 32'd100,        32'd7,          32'd14,         32'd2,          0);
    vt[1]  = mk(1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0);
    vt[2]  = mk(1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0);
    vt[3]  = mk(1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0);
    vt[4]  = mk(0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0);
    vt[5]  = mk(0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1);
    vt[6]  = mk(0, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  0);
    vt[7]  = mk(1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  0);
    vt[8]  = mk(0, 32'd5,          32'd10,         32'd0,          32'd5,          0);
    vt[9]  = mk(1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1);
    vt[10] = mk(0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          0);
    vt[11] = mk(1, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          0);

    // Reset state, before any clock edge.
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(vt[i].s, vt[i].a, vt[i].b, vt[i].exp, 0, $sformatf("vec%0d", i));

    // Start pulsed mid-CALC is ignored.
    run_op(0, 32'd100, 32'd7, rsp(32'd14, 32'd2, 0), 5, "midstart");

    // Cancel in CALC: no completion, results untouched.
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0;
    dif.dividend_i = 32'd999; dif.divisor_i = 32'd4;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 dif.cancel_i = 1'b1;
    @(posedge clk); #1;
    dif.cancel_i = 1'b0;
    chk("cancel_busy", dif.busy, 0);
    count_no_done(40, "cancel_nodone");
    chk("cancel_hold_lo", dif.wLoData, last_lo);
    chk("cancel_hold_hi", dif.wHiData, last_hi);
    run_op(0, 32'd999, 32'd4, rsp(32'd249, 32'd3, 0), 0, "after_cancel");

    // Cancel together with start in IDLE: start not accepted.
    @(negedge clk);
    dif.start_i = 1'b1; dif.cancel_i = 1'b1;
    dif.dividend_i = 32'd50; dif.divisor_i = 32'd0;
    #1 chk("cancel_start_busy", dif.busy, 0);
    @(posedge clk); #1;
    dif.start_i = 1'b0; dif.cancel_i = 1'b0;
    chk("cancel_start_idle", dif.busy, 0);
    count_no_done(5, "cancel_start_nodone");

    // Cancel during FIN masks the write strobes.
    @(negedge clk);
    dif.start_i = 1'b1; dif.dividend_i = 32'd77; dif.divisor_i = 32'd0;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    dif.cancel_i = 1'b1;
    #1;
    chk("fin_cancel_done", dif.done, 0);
    chk("fin_cancel_wlo",  dif.wlo, 0);
    chk("fin_cancel_whi",  dif.whi, 0);
    chk("fin_cancel_dz",   dif.divZero, 0);
    @(posedge clk); #1;
    dif.cancel_i = 1'b0;
    count_no_done(3, "fin_cancel_nodone");

    // Random operands against the reference.
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
      if ($urandom_range(0, 7) == 0) b = (s && $urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 : 32'd0;
      run_op(s, a, b, model(s, a, b), 0, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    dif.start_i = 1'b1; dif.signed_i = 1'b0;
    dif.dividend_i = 32'd12345; dif.divisor_i = 32'd10;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk) rst = 1'b0;
    count_no_done(40, "rst_nodone");
    chk("rst_lo_hold", dif.wLoData, 0);
    run_op(0, 32'd12345, 32'd10, rsp(32'd1234, 32'd5, 0), 0, "after_rst");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
